// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Assigns note-on / note-off events to NUM_CHANNELS synth voices.
//               Each accepted event is resolved by a serial scan of all voices
//               (one voice per cycle), followed by a single channel-write
//               strobe. Per-voice gate, note and age are tracked so that a
//               full pool is arbitrated deterministically. A level all_off
//               request gates off every voice with N consecutive writes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   s_axi_aclk_i     clock
//   s_axi_aresetn_i  synchronous reset, active-low
//   ev_valid_i       note event valid
//   ev_ready_o       event accepted on ev_valid_i & ev_ready_o
//   ev_note_on_i     1 = note-on, 0 = note-off
//   ev_note_i        note number
//   ev_vel_i         velocity (ignored for note-off)
//   all_off_i        level request: gate off every voice
//   ch_we_o          one-cycle channel write strobe
//   ch_sel_o         voice written
//   ch_gate_o        gate value written
//   ch_note_o        note written
//   ch_vel_o         velocity written
//   active_mask_o    current gate of each voice
//   drop_cnt_o       dropped-event count, saturating at 255
//   busy_o           FSM not idle
// Configuration macro
//   VOICE_STEAL_EN   defined: a note-on into a full pool steals the oldest
//                    voice; undefined: such a note-on is dropped.
// ============================================================================
module voice_allocator #(
  parameter int NUM_CHANNELS = 16,
  parameter int NOTE_BITS    = 7,
  parameter int VEL_BITS     = 7,
  // derived from NUM_CHANNELS; not meant to be overridden
  parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                    s_axi_aclk_i,
  input  logic                    s_axi_aresetn_i,
  input  logic                    ev_valid_i,
  output logic                    ev_ready_o,
  input  logic                    ev_note_on_i,
  input  logic [NOTE_BITS-1:0]    ev_note_i,
  input  logic [VEL_BITS-1:0]     ev_vel_i,
  input  logic                    all_off_i,
  output logic                    ch_we_o,
  output logic [CH_BITS-1:0]      ch_sel_o,
  output logic                    ch_gate_o,
  output logic [NOTE_BITS-1:0]    ch_note_o,
  output logic [VEL_BITS-1:0]     ch_vel_o,
  output logic [NUM_CHANNELS-1:0] active_mask_o,
  output logic [7:0]              drop_cnt_o,
  output logic                    busy_o
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_SCAN  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  localparam logic [CH_BITS-1:0] C_LAST     = CH_BITS'(NUM_CHANNELS - 1);
  localparam logic [CH_BITS-1:0] C_ONE      = CH_BITS'(1);
  localparam logic [7:0]         C_DROP_MAX = 8'hFF;

`ifdef VOICE_STEAL_EN
  localparam logic C_STEAL_EN = 1'b1;
`else
  localparam logic C_STEAL_EN = 1'b0;
`endif

  // FSM
  logic [1:0] state_q, state_d;

  // latched event and scan position
  logic                 ev_on_q;
  logic [NOTE_BITS-1:0] ev_note_q;
  logic [VEL_BITS-1:0]  ev_vel_q;
  logic [CH_BITS-1:0]   scan_idx_q;

  // per-voice state
  logic [NUM_CHANNELS-1:0] gate_q;
  logic [NOTE_BITS-1:0]    note_q [NUM_CHANNELS];
  logic [CH_BITS-1:0]      age_q  [NUM_CHANNELS];

  // running scan results
  logic               hit_found_q, free_found_q;
  logic [CH_BITS-1:0] hit_idx_q, free_idx_q, old_idx_q, old_age_q;

  // channel write port
  logic                 ch_we_q, ch_gate_q;
  logic [CH_BITS-1:0]   ch_sel_q;
  logic [NOTE_BITS-1:0] ch_note_q;
  logic [VEL_BITS-1:0]  ch_vel_q;
  logic [7:0]           drop_q;

  // scan evaluation
  logic               w_cur_gate, w_cur_hit, w_old_take, w_scan_last;
  logic [NOTE_BITS-1:0] w_cur_note;
  logic [CH_BITS-1:0] w_cur_age;
  logic               w_hit_found, w_free_found;
  logic [CH_BITS-1:0] w_hit_idx, w_free_idx, w_old_idx, w_old_age;
  logic               w_do_write;
  logic [CH_BITS-1:0] w_sel, w_clr_idx;

  // --------------------------------------------------------------------------
  // Scan evaluation: fold the current voice into the running results. On the
  // last scan cycle these folded values are the final answer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cur_gate  = gate_q[scan_idx_q];
    w_cur_note  = note_q[scan_idx_q];
    w_cur_age   = age_q[scan_idx_q];
    w_cur_hit   = w_cur_gate && (w_cur_note == ev_note_q);
    w_scan_last = (scan_idx_q == C_LAST);

    w_hit_found  = hit_found_q | w_cur_hit;
    w_hit_idx    = hit_found_q ? hit_idx_q : scan_idx_q;
    w_free_found = free_found_q | ~w_cur_gate;
    w_free_idx   = free_found_q ? free_idx_q : scan_idx_q;

    // strict compare keeps the lowest index on equal ages
    w_old_take = (scan_idx_q == '0) || (w_cur_age > old_age_q);
    w_old_idx  = w_old_take ? scan_idx_q : old_idx_q;
    w_old_age  = w_old_take ? w_cur_age  : old_age_q;
  end

  // Voice selection for the latched event
  always_comb begin
    w_do_write = 1'b0;
    w_sel      = w_hit_idx;
    if (ev_on_q) begin
      if (w_hit_found) begin
        w_do_write = 1'b1;
        w_sel      = w_hit_idx;
      end else if (w_free_found) begin
        w_do_write = 1'b1;
        w_sel      = w_free_idx;
      end else begin
        w_do_write = C_STEAL_EN;
        w_sel      = w_old_idx;
      end
    end else begin
      w_do_write = w_hit_found;
      w_sel      = w_hit_idx;
    end
  end

  // during CLEAR, ch_sel_q holds the voice cleared last
  assign w_clr_idx = ch_sel_q + C_ONE;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk_i) begin
    if (!s_axi_aresetn_i) state_q <= C_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (all_off_i)       state_d = C_CLEAR;
        else if (ev_valid_i) state_d = C_SCAN;
      end
      C_SCAN: begin
        if (w_scan_last) state_d = w_do_write ? C_WRITE : C_IDLE;
      end
      C_WRITE: state_d = C_IDLE;
      C_CLEAR: begin
        if (ch_sel_q == C_LAST) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    ev_ready_o = (state_q == C_IDLE) && !all_off_i;
    busy_o     = (state_q != C_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath: event latch, scan accumulators, voice table, write port
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk_i) begin
    if (!s_axi_aresetn_i) begin
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      ev_vel_q     <= '0;
      scan_idx_q   <= '0;
      gate_q       <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
      hit_found_q  <= 1'b0;
      free_found_q <= 1'b0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      ch_we_q      <= 1'b0;
      ch_sel_q     <= '0;
      ch_gate_q    <= 1'b0;
      ch_note_q    <= '0;
      ch_vel_q     <= '0;
      drop_q       <= '0;
    end else begin
      ch_we_q <= 1'b0;
      case (state_q)
        C_IDLE: begin
          if (all_off_i) begin
            // first gate-off write (voice 0) issues on the entry edge
            ch_we_q   <= 1'b1;
            ch_sel_q  <= '0;
            ch_gate_q <= 1'b0;
            ch_note_q <= note_q[0];
            ch_vel_q  <= '0;
            gate_q[0] <= 1'b0;
            age_q[0]  <= '0;
          end else if (ev_valid_i) begin
            ev_on_q      <= ev_note_on_i;
            ev_note_q    <= ev_note_i;
            ev_vel_q     <= ev_vel_i;
            scan_idx_q   <= '0;
            hit_found_q  <= 1'b0;
            free_found_q <= 1'b0;
          end
        end
        C_SCAN: begin
          scan_idx_q   <= scan_idx_q + C_ONE;
          hit_found_q  <= w_hit_found;
          hit_idx_q    <= w_hit_idx;
          free_found_q <= w_free_found;
          free_idx_q   <= w_free_idx;
          old_idx_q    <= w_old_idx;
          old_age_q    <= w_old_age;
          if (w_scan_last) begin
            if (w_do_write) begin
              ch_we_q       <= 1'b1;
              ch_sel_q      <= w_sel;
              ch_gate_q     <= ev_on_q;
              ch_note_q     <= ev_note_q;
              ch_vel_q      <= ev_on_q ? ev_vel_q : '0;
              gate_q[w_sel] <= ev_on_q;
              note_q[w_sel] <= ev_note_q;
              if (ev_on_q) begin
                // selected voice becomes youngest; every other sounding voice ages
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                  if (CH_BITS'(i) == w_sel)
                    age_q[i] <= '0;
                  else if (gate_q[i] && (age_q[i] != C_LAST))
                    age_q[i] <= age_q[i] + C_ONE;
                end
              end else begin
                age_q[w_sel] <= '0;
              end
            end else if (drop_q != C_DROP_MAX) begin
              drop_q <= drop_q + 8'd1;
            end
          end
        end
        C_CLEAR: begin
          if (ch_sel_q != C_LAST) begin
            ch_we_q           <= 1'b1;
            ch_sel_q          <= w_clr_idx;
            ch_gate_q         <= 1'b0;
            ch_note_q         <= note_q[w_clr_idx];
            ch_vel_q          <= '0;
            gate_q[w_clr_idx] <= 1'b0;
            age_q[w_clr_idx]  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_we_o       = ch_we_q;
  assign ch_sel_o      = ch_sel_q;
  assign ch_gate_o     = ch_gate_q;
  assign ch_note_o     = ch_note_q;
  assign ch_vel_o      = ch_vel_q;
  assign active_mask_o = gate_q;
  assign drop_cnt_o    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Self-checking bench for voice_allocator: table of directed
//               events, hand-written pool-full / all_off / reset sequences,
//               and random events checked against a voice-pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  localparam int N = 16;

`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_note_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [6:0]  ev_vel = '0;
  logic        all_off = 1'b0;
  logic        ch_we;
  logic [3:0]  ch_sel;
  logic        ch_gate;
  logic [6:0]  ch_note;
  logic [6:0]  ch_vel;
  logic [15:0] active_mask;
  logic [7:0]  drop_cnt;
  logic        busy;

  voice_allocator #(.NUM_CHANNELS(N), .NOTE_BITS(7), .VEL_BITS(7)) dut (
    .s_axi_aclk_i    (clk),
    .s_axi_aresetn_i (rstn),
    .ev_valid_i      (ev_valid),
    .ev_ready_o      (ev_ready),
    .ev_note_on_i    (ev_note_on),
    .ev_note_i       (ev_note),
    .ev_vel_i        (ev_vel),
    .all_off_i       (all_off),
    .ch_we_o         (ch_we),
    .ch_sel_o        (ch_sel),
    .ch_gate_o       (ch_gate),
    .ch_note_o       (ch_note),
    .ch_vel_o        (ch_vel),
    .active_mask_o   (active_mask),
    .drop_cnt_o      (drop_cnt),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- observation of one event ----------------
  int o_we_count, o_we_cyc, o_sel, o_gate, o_note, o_vel, o_rdy_cyc, o_mask, o_drop;

  // k counts falling edges after the accepting rising edge (k=1 is the first)
  task automatic issue(input bit on, input int n, input int v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ev_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_event", int'(ev_ready), 1);
    ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(n); ev_vel = 7'(v);
    @(posedge clk);
    o_we_count = 0; o_we_cyc = 0; o_rdy_cyc = 0;
    o_sel = 0; o_gate = 0; o_note = 0; o_vel = 0;
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (k == 1) ev_valid = 1'b0;
      if (ch_we === 1'b1) begin
        o_we_count++;
        o_we_cyc = k;
        o_sel = int'(ch_sel); o_gate = int'(ch_gate);
        o_note = int'(ch_note); o_vel = int'(ch_vel);
      end
      if (ev_ready === 1'b1 && o_rdy_cyc == 0) o_rdy_cyc = k;
    end
    o_mask = int'(active_mask);
    o_drop = int'(drop_cnt);
  endtask

  // ---------------- reference model: the voice pool ----------------
  int m_gate [N];
  int m_note [N];
  int m_age  [N];
  int m_drop;
  int e_we, e_sel, e_gate, e_note, e_vel, e_mask;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_note[i] = 0; m_age[i] = 0; end
    m_drop = 0;
  endtask

  task automatic model_event(input bit on, input int n, input int v);
    int sel;
    sel = -1;
    for (int i = 0; i < N; i++)
      if (sel < 0 && m_gate[i] != 0 && m_note[i] == n) sel = i;
    if (on) begin
      for (int i = 0; i < N; i++)
        if (sel < 0 && m_gate[i] == 0) sel = i;
      if (sel < 0 && STEAL) begin
        sel = 0;
        for (int i = 1; i < N; i++)
          if (m_age[i] > m_age[sel]) sel = i;
      end
    end
    e_we = (sel >= 0) ? 1 : 0;
    if (sel >= 0) begin
      e_sel = sel; e_gate = on ? 1 : 0; e_note = n; e_vel = on ? v : 0;
      if (on)
        for (int i = 0; i < N; i++)
          if (i != sel && m_gate[i] != 0) m_age[i] = (m_age[i] + 1 > N - 1) ? N - 1 : m_age[i] + 1;
      m_age[sel] = 0; m_gate[sel] = on ? 1 : 0; m_note[sel] = n;
    end else if (m_drop < 255) begin
      m_drop++;
    end
    e_mask = 0;
    for (int i = 0; i < N; i++) if (m_gate[i] != 0) e_mask |= (1 << i);
  endtask

  task automatic check_vs_model(input string tag);
    chk({tag, ".we_count"}, o_we_count, e_we);
    if (e_we != 0) begin
      chk({tag, ".we_cycle"}, o_we_cyc, N + 1);
      chk({tag, ".sel"}, o_sel, e_sel);
      chk({tag, ".gate"}, o_gate, e_gate);
      chk({tag, ".note"}, o_note, e_note);
      chk({tag, ".vel"}, o_vel, e_vel);
      chk({tag, ".ready_cycle"}, o_rdy_cyc, N + 2);
    end else begin
      chk({tag, ".ready_cycle"}, o_rdy_cyc, N + 1);
    end
    chk({tag, ".mask"}, o_mask, e_mask);
    chk({tag, ".drop"}, o_drop, m_drop);
  endtask

  task automatic run_model(input bit on, input int n, input int v, input string tag);
    model_event(on, n, v);
    issue(on, n, v);
    check_vs_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; ev_valid = 1'b0; all_off = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset.ch_we", int'(ch_we), 0);
    chk("reset.mask", int'(active_mask), 0);
    chk("reset.drop", int'(drop_cnt), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.ready", int'(ev_ready), 1);
    model_reset();
  endtask

  // all_off held for 'hold' falling edges; optional competing event
  task automatic do_all_off(input bit with_valid, input int hold);
    int cnt;
    @(negedge clk);
    all_off = 1'b1; ev_valid = with_valid; ev_note_on = 1'b1; ev_note = 7'd100; ev_vel = 7'd1;
    #1 chk("alloff.ready_low", int'(ev_ready), 0);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == hold) begin all_off = 1'b0; ev_valid = 1'b0; end
      if (ch_we === 1'b1) begin
        chk("alloff.sel", int'(ch_sel), cnt % N);
        chk("alloff.gate", int'(ch_gate), 0);
        cnt++;
      end
    end
    if (hold == 1) chk("alloff.write_count", cnt, N);
    else           chk("alloff.reentered", (cnt > N) ? 1 : 0, 1);
    chk("alloff.mask", int'(active_mask), 0);
    chk("alloff.drop", int'(drop_cnt), m_drop);
    chk("alloff.busy", int'(busy), 0);
    for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_age[i] = 0; end
  endtask

  typedef struct {
    bit on; int note; int vel;
    bit we; int sel; int gate; int mask; int drop;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cnt;
    tbl[0] = '{1'b1, 60, 100, 1'b1, 0, 1, 'h0001, 0};
    tbl[1] = '{1'b1, 60,  90, 1'b1, 0, 1, 'h0001, 0};
    tbl[2] = '{1'b1, 62,  80, 1'b1, 1, 1, 'h0003, 0};
    tbl[3] = '{1'b1, 64,  70, 1'b1, 2, 1, 'h0007, 0};
    tbl[4] = '{1'b0, 62,  55, 1'b1, 1, 0, 'h0005, 0};
    tbl[5] = '{1'b1, 67,  10, 1'b1, 1, 1, 'h0007, 0};
    tbl[6] = '{1'b0, 99,  20, 1'b0, 0, 0, 'h0007, 1};
    tbl[7] = '{1'b0, 60,  33, 1'b1, 0, 0, 'h0006, 1};
    tbl[8] = '{1'b0, 60,  33, 1'b0, 0, 0, 'h0006, 2};
    tbl[9] = '{1'b1,  5, 127, 1'b1, 0, 1, 'h0007, 2};

    do_reset();

    // directed table
    for (int i = 0; i < 10; i++) begin
      model_event(tbl[i].on, tbl[i].note, tbl[i].vel);
      issue(tbl[i].on, tbl[i].note, tbl[i].vel);
      chk($sformatf("tbl%0d.we_count", i), o_we_count, tbl[i].we ? 1 : 0);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d.we_cycle", i), o_we_cyc, 17);
        chk($sformatf("tbl%0d.sel", i), o_sel, tbl[i].sel);
        chk($sformatf("tbl%0d.gate", i), o_gate, tbl[i].gate);
        chk($sformatf("tbl%0d.note", i), o_note, tbl[i].note);
        chk($sformatf("tbl%0d.vel", i), o_vel, tbl[i].on ? tbl[i].vel : 0);
        chk($sformatf("tbl%0d.ready_cycle", i), o_rdy_cyc, 18);
      end else begin
        chk($sformatf("tbl%0d.ready_cycle", i), o_rdy_cyc, 17);
      end
      chk($sformatf("tbl%0d.mask", i), o_mask, tbl[i].mask);
      chk($sformatf("tbl%0d.drop", i), o_drop, tbl[i].drop);
    end

    // full pool, then one more note-on
    do_reset();
    for (int i = 0; i < N; i++) run_model(1'b1, 40 + i, 64, "fill");
    model_event(1'b1, 70, 50);
    issue(1'b1, 70, 50);
`ifdef VOICE_STEAL_EN
    chk("full.steal_we", o_we_count, 1);
    chk("full.steal_sel", o_sel, 0);
`else
    chk("full.drop_we", o_we_count, 0);
    chk("full.drop_cnt", o_drop, 1);
`endif
    check_vs_model("full");
    run_model(1'b1, 71, 51, "full2");

    // all_off against a competing event with a full pool, then held all_off
    do_all_off(1'b1, 1);
    do_all_off(1'b0, 30);

    // reset in the middle of a scan
    run_model(1'b1, 10, 1, "pre_rst");
    run_model(1'b1, 11, 2, "pre_rst");
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd50; ev_vel = 7'd3;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cnt = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (ch_we === 1'b1) cnt++;
    end
    chk("midscan.no_write", cnt, 0);
    chk("midscan.mask", int'(active_mask), 0);
    chk("midscan.drop", int'(drop_cnt), 0);
    chk("midscan.ready", int'(ev_ready), 1);

    // random events against the model
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 99) < 4) begin
        do_all_off(1'b0, 1);
      end else begin
        run_model($urandom_range(0, 99) < 62, 40 + int'($urandom_range(0, 23)),
                  int'($urandom_range(0, 127)), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
